// File: rtl/histogram_frame_controller_pkg.sv
// Shared types and default dimensions for the histogram frame controller.
package hist_ctrl_pkg;

    localparam int ADDR_W          = 8;
    localparam int BIN_W           = 8;
    localparam int DEF_X_WIDTH     = 240;
    localparam int DEF_Y_HEIGHT    = 180;
    localparam int DEF_STOP_CYCLES = 2;
    localparam int DEF_TIMEOUT     = 1023;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_SCAN     = 3'd2,
        S_STOP     = 3'd3,
        S_READ     = 3'd4,
        S_COLLECT  = 3'd5,
        S_CLEAR    = 3'd6,
        S_WAIT_CLR = 3'd7
    } state_t;

endpackage

// File: rtl/histogram_frame_controller_if.sv
// Pixel stream, histogram control/read bus and frame status of the controller.
interface histogram_frame_controller_if;
    import hist_ctrl_pkg::*;

    logic              frameStart;
    logic              abort;
    logic              pixelIn;
    logic              pixelValid;
    logic              pixelReady;
    logic [ADDR_W-1:0] xAddress;
    logic [ADDR_W-1:0] yAddress;
    logic              pixelData;
    logic              startHistogram;
    logic              stopHistogram;
    logic              readHistogram;
    logic              clearHistogram;
    logic [BIN_W-1:0]  xHistogramOut;
    logic [BIN_W-1:0]  yHistogramOut;
    logic              xValid;
    logic              yValid;
    logic              histogramClear;
    logic [ADDR_W-1:0] xPeakIdx;
    logic [ADDR_W-1:0] yPeakIdx;
    logic [BIN_W-1:0]  xPeakCnt;
    logic [BIN_W-1:0]  yPeakCnt;
    logic              resultValid;
    logic              busy;
    logic              timeoutErr;

    modport master (
        input  frameStart, abort, pixelIn, pixelValid,
        input  xHistogramOut, yHistogramOut, xValid, yValid, histogramClear,
        output pixelReady, xAddress, yAddress, pixelData,
        output startHistogram, stopHistogram, readHistogram, clearHistogram,
        output xPeakIdx, yPeakIdx, xPeakCnt, yPeakCnt,
        output resultValid, busy, timeoutErr
    );

    modport slave (
        output frameStart, abort, pixelIn, pixelValid,
        output xHistogramOut, yHistogramOut, xValid, yValid, histogramClear,
        input  pixelReady, xAddress, yAddress, pixelData,
        input  startHistogram, stopHistogram, readHistogram, clearHistogram,
        input  xPeakIdx, yPeakIdx, xPeakCnt, yPeakCnt,
        input  resultValid, busy, timeoutErr
    );

endinterface

// File: rtl/histogram_frame_controller_peak.sv
// Running maximum of a valid-qualified count stream; ties keep the earliest index.
module hist_peak_tracker #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [IDX_W-1:0] o_max_idx,
    output logic [CNT_W-1:0] o_max_cnt
);

    logic [IDX_W-1:0] r_max_idx;
    logic [CNT_W-1:0] r_max_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_max_idx <= '0;
            r_max_cnt <= '0;
        end else if (i_valid && (i_cnt > r_max_cnt)) begin
            r_max_idx <= i_idx;
            r_max_cnt <= i_cnt;
        end
    end

    assign o_max_idx = r_max_idx;
    assign o_max_cnt = r_max_cnt;

endmodule

// File: rtl/histogram_frame_controller.sv
// Frame sequencer for computeHistogram: rasterises the pixel stream, drives the
// histogram control pulses and reports the peak x/y bin of each frame.
//   state    | meaning
//   IDLE     | waiting for frameStart
//   START    | startHistogram pulse, addresses (0,0)
//   SCAN     | accepting pixels, x outer / y inner
//   STOP     | stopHistogram for STOP_CYCLES cycles
//   READ     | readHistogram pulse
//   COLLECT  | tracking peaks over the streamed bins
//   CLEAR    | clearHistogram pulse
//   WAIT_CLR | waiting for histogramClear
module histogram_frame_controller
    import hist_ctrl_pkg::*;
#(
    parameter int X_WIDTH     = DEF_X_WIDTH,
    parameter int Y_HEIGHT    = DEF_Y_HEIGHT,
    parameter int STOP_CYCLES = DEF_STOP_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    histogram_frame_controller_if.master bus
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int TMR_MAX = (TIMEOUT > STOP_CYCLES) ? TIMEOUT : STOP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(X_WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(Y_HEIGHT - 1);
    localparam logic [CNT_W-1:0]  X_BEATS  = CNT_W'(X_WIDTH);
    localparam logic [CNT_W-1:0]  Y_BEATS  = CNT_W'(Y_HEIGHT);
    localparam logic [TMR_W-1:0]  TMR_TO   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_STOP = TMR_W'(STOP_CYCLES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_y;
    logic [CNT_W-1:0]  r_xb;
    logic [CNT_W-1:0]  r_yb;
    logic [TMR_W-1:0]  r_tmr;

    logic              r_ready;
    logic [ADDR_W-1:0] r_xaddr;
    logic [ADDR_W-1:0] r_yaddr;
    logic              r_pdata;
    logic              r_start;
    logic              r_stop;
    logic              r_read;
    logic              r_clear;
    logic [ADDR_W-1:0] r_xpk_idx;
    logic [ADDR_W-1:0] r_ypk_idx;
    logic [BIN_W-1:0]  r_xpk_cnt;
    logic [BIN_W-1:0]  r_ypk_cnt;
    logic              r_result;
    logic              r_busy;
    logic              r_err;

    logic              w_abort;
    logic              w_xbeat;
    logic              w_ybeat;
    logic              w_trk_clr;
    logic [ADDR_W-1:0] w_xmax_idx;
    logic [ADDR_W-1:0] w_ymax_idx;
    logic [BIN_W-1:0]  w_xmax_cnt;
    logic [BIN_W-1:0]  w_ymax_cnt;

    assign w_abort   = bus.abort &&
                       (r_state inside {S_START, S_SCAN, S_STOP, S_READ, S_COLLECT});
    // Beats past the expected bin count are dropped before reaching the trackers.
    assign w_xbeat   = (r_state == S_COLLECT) && bus.xValid && (r_xb < X_BEATS);
    assign w_ybeat   = (r_state == S_COLLECT) && bus.yValid && (r_yb < Y_BEATS);
    assign w_trk_clr = (r_state == S_READ);

    hist_peak_tracker #(.IDX_W(ADDR_W), .CNT_W(BIN_W)) u_x_peak (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_trk_clr),
        .i_valid   (w_xbeat),
        .i_idx     (r_xb[ADDR_W-1:0]),
        .i_cnt     (bus.xHistogramOut),
        .o_max_idx (w_xmax_idx),
        .o_max_cnt (w_xmax_cnt)
    );

    hist_peak_tracker #(.IDX_W(ADDR_W), .CNT_W(BIN_W)) u_y_peak (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_trk_clr),
        .i_valid   (w_ybeat),
        .i_idx     (r_yb[ADDR_W-1:0]),
        .i_cnt     (bus.yHistogramOut),
        .o_max_idx (w_ymax_idx),
        .o_max_cnt (w_ymax_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_xb      <= '0;
            r_yb      <= '0;
            r_tmr     <= '0;
            r_ready   <= 1'b0;
            r_xaddr   <= '0;
            r_yaddr   <= '0;
            r_pdata   <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_read    <= 1'b0;
            r_clear   <= 1'b0;
            r_xpk_idx <= '0;
            r_ypk_idx <= '0;
            r_xpk_cnt <= '0;
            r_ypk_cnt <= '0;
            r_result  <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start  <= 1'b0;
            r_read   <= 1'b0;
            r_clear  <= 1'b0;
            r_result <= 1'b0;
            if (w_xbeat) r_xb <= r_xb + 1'b1;
            if (w_ybeat) r_yb <= r_yb + 1'b1;

            if (w_abort) begin
                r_state <= S_CLEAR;
                r_clear <= 1'b1;
                r_ready <= 1'b0;
                r_pdata <= 1'b0;
                r_stop  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.frameStart) begin
                            r_state <= S_START;
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_xaddr <= '0;
                            r_yaddr <= '0;
                            r_pdata <= 1'b0;
                        end
                    end
                    S_START: begin
                        r_state <= S_SCAN;
                        r_ready <= 1'b1;
                    end
                    S_SCAN: begin
                        if (bus.pixelValid) begin
                            r_pdata <= bus.pixelIn;
                            r_xaddr <= r_x;
                            r_yaddr <= r_y;
                            if (r_y == Y_LAST) begin
                                r_y <= '0;
                                if (r_x == X_LAST) begin
                                    r_state <= S_STOP;
                                    r_ready <= 1'b0;
                                    r_tmr   <= TMR_STOP;
                                end else begin
                                    r_x <= r_x + 1'b1;
                                end
                            end else begin
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            r_pdata <= 1'b0;
                        end
                    end
                    // First STOP cycle still presents the last pixel, so the
                    // stop pulse starts one cycle later and never overlaps data.
                    S_STOP: begin
                        r_pdata <= 1'b0;
                        if (r_tmr == '0) begin
                            r_stop  <= 1'b0;
                            r_read  <= 1'b1;
                            r_state <= S_READ;
                        end else begin
                            r_stop <= 1'b1;
                            r_tmr  <= r_tmr - 1'b1;
                        end
                    end
                    S_READ: begin
                        r_state <= S_COLLECT;
                        r_tmr   <= TMR_TO;
                        r_xb    <= '0;
                        r_yb    <= '0;
                    end
                    S_COLLECT: begin
                        if ((r_xb == X_BEATS) && (r_yb == Y_BEATS)) begin
                            r_xpk_idx <= w_xmax_idx;
                            r_xpk_cnt <= w_xmax_cnt;
                            r_ypk_idx <= w_ymax_idx;
                            r_ypk_cnt <= w_ymax_cnt;
                            r_result  <= 1'b1;
                            r_clear   <= 1'b1;
                            r_state   <= S_CLEAR;
                        end else if (r_tmr == '0) begin
                            r_err   <= 1'b1;
                            r_clear <= 1'b1;
                            r_state <= S_CLEAR;
                        end else begin
                            r_tmr <= r_tmr - 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        r_state <= S_WAIT_CLR;
                        r_tmr   <= TMR_TO;
                    end
                    S_WAIT_CLR: begin
                        if (bus.histogramClear) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_tmr == '0) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_tmr <= r_tmr - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pixelReady     = r_ready;
    assign bus.xAddress       = r_xaddr;
    assign bus.yAddress       = r_yaddr;
    assign bus.pixelData      = r_pdata;
    assign bus.startHistogram = r_start;
    assign bus.stopHistogram  = r_stop;
    assign bus.readHistogram  = r_read;
    assign bus.clearHistogram = r_clear;
    assign bus.xPeakIdx       = r_xpk_idx;
    assign bus.yPeakIdx       = r_ypk_idx;
    assign bus.xPeakCnt       = r_xpk_cnt;
    assign bus.yPeakCnt       = r_ypk_cnt;
    assign bus.resultValid    = r_result;
    assign bus.busy           = r_busy;
    assign bus.timeoutErr     = r_err;

endmodule

// File: tb/tb_histogram_frame_controller.sv
// Randomised frame-level bench: the bench plays pixel source and histogram, and
// compares the controller against peaks computed directly from the frame image.
module tb_histogram_frame_controller;

    localparam int XW   = 24;
    localparam int YH   = 18;
    localparam int NPIX = XW * YH;
    localparam int TMO  = 300;
    localparam int SC   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    histogram_frame_controller_if hif ();

    histogram_frame_controller #(
        .X_WIDTH(XW), .Y_HEIGHT(YH), .STOP_CYCLES(SC), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    int n_chk, n_fail;

    bit pix [XW][YH];
    int hx [XW];
    int hy [YH];
    int ex_xi, ex_xc, ex_yi, ex_yc;
    int last_xi, last_xc, last_yi, last_yc;

    bit mon_en;
    int n_acc, n_start, n_stop, n_read, n_clear, n_res, n_bad;
    bit prev_ready, prev_xfer, exp_d;
    int exp_x, exp_y;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Stream observer: pulse counts and per-cycle raster checks of the pixel outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hif.startHistogram) begin
                n_start++;
                if (hif.xAddress != 0 || hif.yAddress != 0) n_bad++;
            end
            if (hif.stopHistogram) begin
                n_stop++;
                if (hif.pixelData) n_bad++;
            end
            if (hif.readHistogram)  n_read++;
            if (hif.clearHistogram) n_clear++;
            if (hif.resultValid)    n_res++;
            if (n_acc >= NPIX && hif.pixelReady) n_bad++;
            if (prev_ready) begin
                if (int'(hif.xAddress) != exp_x || int'(hif.yAddress) != exp_y) n_bad++;
                if (hif.pixelData != (prev_xfer ? exp_d : 1'b0)) n_bad++;
            end
            prev_ready = hif.pixelReady;
            prev_xfer  = hif.pixelReady && hif.pixelValid;
            if (prev_xfer) begin
                exp_x = n_acc / YH;
                exp_y = n_acc % YH;
                exp_d = hif.pixelIn;
                n_acc++;
            end
        end
    end

    task automatic fill(input int mode);
        for (int x = 0; x < XW; x++) begin
            int lim;
            lim = $urandom_range(0, 11);
            for (int y = 0; y < YH; y++) begin
                case (mode)
                    0: pix[x][y] = 1'b0;
                    1: pix[x][y] = (x == 17);
                    2: pix[x][y] = (x == 5 || x == 9) ? (y < 12) : (y < lim);
                    default: pix[x][y] = 1'($urandom);
                endcase
            end
        end
    endtask

    // Reference: bin sums from the image, then the first bin holding the maximum.
    task automatic model();
        int mx;
        for (int x = 0; x < XW; x++) hx[x] = 0;
        for (int y = 0; y < YH; y++) hy[y] = 0;
        for (int x = 0; x < XW; x++)
            for (int y = 0; y < YH; y++)
                if (pix[x][y]) begin
                    hx[x]++;
                    hy[y]++;
                end
        mx = 0;
        foreach (hx[i]) if (hx[i] > mx) mx = hx[i];
        ex_xc = mx;
        ex_xi = -1;
        foreach (hx[i]) if (ex_xi < 0 && hx[i] == mx) ex_xi = i;
        mx = 0;
        foreach (hy[i]) if (hy[i] > mx) mx = hy[i];
        ex_yc = mx;
        ex_yi = -1;
        foreach (hy[i]) if (ex_yi < 0 && hy[i] == mx) ex_yi = i;
    endtask

    task automatic wait_sig(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            case (which)
                0: ok = (n_read != 0);
                1: ok = (n_res != 0);
                2: ok = (n_clear != 0);
                default: ok = !hif.busy;
            endcase
            if (ok) break;
        end
    endtask

    task automatic run_frame(input string nm, input int gap, input int abort_at, input bit do_clr);
        bit ok, aborted;
        int idx, cyc, xi, yi;
        bit xv, yv;
        model();
        aborted = (abort_at >= 0);
        n_acc = 0; n_start = 0; n_stop = 0; n_read = 0; n_clear = 0; n_res = 0; n_bad = 0;
        prev_ready = 1'b0; prev_xfer = 1'b0; exp_x = 0; exp_y = 0; exp_d = 1'b0;
        mon_en = 1'b1;
        hif.frameStart = 1'b1;
        @(posedge clk); #1;
        hif.frameStart = 1'b0;
        chk({nm, "_busy_start"}, hif.busy, 1);
        chk({nm, "_err_cleared"}, hif.timeoutErr, 0);

        idx = 0; cyc = 0;
        while (idx < NPIX && cyc < 4 * NPIX + 50) begin
            if (aborted && idx == abort_at) break;
            hif.pixelValid = ($urandom_range(99) >= gap);
            hif.pixelIn = hif.pixelValid ? pix[idx / YH][idx % YH] : 1'($urandom);
            if (hif.pixelValid && hif.pixelReady) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        hif.pixelValid = 1'b0;
        chk({nm, "_scan_count"}, idx, aborted ? abort_at : NPIX);

        if (aborted) begin
            hif.abort = 1'b1;
            @(posedge clk); #1;
            hif.abort = 1'b0;
            chk({nm, "_clear_next"}, hif.clearHistogram, 1);
        end else begin
            wait_sig(0, 20, ok);
            chk({nm, "_read_seen"}, ok, 1);
            @(posedge clk); #1;
            xi = 0; yi = 0; cyc = 0;
            while ((xi < XW + 3 || yi < YH) && cyc < 400) begin
                xv = (xi < XW + 3) && ($urandom_range(1) == 1);
                yv = (yi < YH) && (xi >= XW) && ($urandom_range(1) == 1);
                hif.xValid = xv;
                hif.yValid = yv;
                hif.xHistogramOut = xv ? ((xi < XW) ? 8'(hx[xi]) : 8'hFF) : 8'($urandom);
                hif.yHistogramOut = yv ? 8'(hy[yi]) : 8'($urandom);
                if (xv) xi++;
                if (yv) yi++;
                @(posedge clk); #1;
                cyc++;
            end
            hif.xValid = 1'b0;
            hif.yValid = 1'b0;
            wait_sig(1, 50, ok);
            chk({nm, "_result_seen"}, ok, 1);
            last_xi = ex_xi; last_xc = ex_xc; last_yi = ex_yi; last_yc = ex_yc;
        end
        chk({nm, "_xpeak_idx"}, hif.xPeakIdx, last_xi);
        chk({nm, "_xpeak_cnt"}, hif.xPeakCnt, last_xc);
        chk({nm, "_ypeak_idx"}, hif.yPeakIdx, last_yi);
        chk({nm, "_ypeak_cnt"}, hif.yPeakCnt, last_yc);

        wait_sig(2, 20, ok);
        chk({nm, "_clear_seen"}, ok, 1);
        if (do_clr) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            hif.histogramClear = 1'b1;
            @(posedge clk); #1;
            hif.histogramClear = 1'b0;
            wait_sig(3, 10, ok);
            chk({nm, "_idle"}, ok, 1);
            chk({nm, "_no_err"}, hif.timeoutErr, 0);
        end else begin
            repeat (50) @(posedge clk);
            #1;
            hif.frameStart = 1'b1;
            @(posedge clk); #1;
            hif.frameStart = 1'b0;
            wait_sig(3, TMO + 20, ok);
            chk({nm, "_tmo_idle"}, ok, 1);
            chk({nm, "_tmo_err"}, hif.timeoutErr, 1);
            chk({nm, "_tmo_busy"}, hif.busy, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk({nm, "_accepted"}, n_acc, aborted ? abort_at : NPIX);
        chk({nm, "_start_pulses"}, n_start, 1);
        chk({nm, "_stop_cycles"}, n_stop, aborted ? 0 : SC);
        chk({nm, "_read_pulses"}, n_read, aborted ? 0 : 1);
        chk({nm, "_clear_pulses"}, n_clear, 1);
        chk({nm, "_result_pulses"}, n_res, aborted ? 0 : 1);
        chk({nm, "_stream_errs"}, n_bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv_xi, sv_xc, sv_yi, sv_yc;
        n_chk = 0; n_fail = 0; mon_en = 1'b0;
        last_xi = 0; last_xc = 0; last_yi = 0; last_yc = 0;
        hif.frameStart = 1'b0; hif.abort = 1'b0; hif.pixelIn = 1'b0; hif.pixelValid = 1'b0;
        hif.xHistogramOut = '0; hif.yHistogramOut = '0; hif.xValid = 1'b0; hif.yValid = 1'b0;
        hif.histogramClear = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", hif.busy, 0);
        chk("rst_ready", hif.pixelReady, 0);
        chk("rst_ctrl", {hif.startHistogram, hif.stopHistogram, hif.readHistogram, hif.clearHistogram}, 0);
        chk("rst_result", hif.resultValid, 0);
        chk("rst_err", hif.timeoutErr, 0);
        chk("rst_addr", {hif.xAddress, hif.yAddress, hif.pixelData}, 0);
        chk("rst_peaks", {hif.xPeakIdx, hif.xPeakCnt, hif.yPeakIdx, hif.yPeakCnt}, 0);

        fill(0); run_frame("zeros", 0, -1, 1);
        chk("zeros_xcnt_const", hif.xPeakCnt, 0);

        fill(1); run_frame("col17", 0, -1, 1);
        chk("col17_xi_const", hif.xPeakIdx, 17);
        chk("col17_xc_const", hif.xPeakCnt, YH);
        chk("col17_yi_const", hif.yPeakIdx, 0);
        chk("col17_yc_const", hif.yPeakCnt, 1);

        fill(3); run_frame("rnd_nogap", 0, -1, 1);
        sv_xi = hif.xPeakIdx; sv_xc = hif.xPeakCnt; sv_yi = hif.yPeakIdx; sv_yc = hif.yPeakCnt;
        run_frame("rnd_gap", 50, -1, 1);
        chk("gap_vs_nogap", {8'(hif.xPeakIdx), 8'(hif.xPeakCnt), 8'(hif.yPeakIdx), 8'(hif.yPeakCnt)},
            {8'(sv_xi), 8'(sv_xc), 8'(sv_yi), 8'(sv_yc)});

        fill(2); run_frame("ties", 30, -1, 1);
        chk("ties_xi_const", hif.xPeakIdx, 5);

        fill(3); run_frame("abort", 20, 100, 1);
        fill(3); run_frame("tmo", 50, -1, 0);
        fill(3); run_frame("after_tmo", 10, -1, 1);
        for (int k = 0; k < 3; k++) begin
            fill(3);
            run_frame($sformatf("rnd%0d", k), $urandom_range(0, 60), -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_frame_controller.md
Name: histogram_frame_controller

Overview:
Frame-level sequencer for the computeHistogram block. Accepts a binary pixel stream over a valid/ready handshake and rasterises it into xAddress/yAddress/pixelData, x outer and y inner. Issues the start, stop, read and clear pulses, then collects the streamed x/y histograms and reports the peak bin of each axis per frame. Sits between the thresholding stage and the tracking logic.

Parameters:
X_WIDTH, 240, columns per frame (x bins)
Y_HEIGHT, 180, rows per frame (y bins)
ADDR_W, 8, address width; must satisfy 2^ADDR_W >= max(X_WIDTH, Y_HEIGHT)
BIN_W, 8, histogram bin width
STOP_CYCLES, 2, stopHistogram pulse length in cycles
TIMEOUT, 1023, maximum cycles to wait in COLLECT or WAIT_CLR

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; returns the block to IDLE
frameStart  in  1  one-cycle request to process one frame; ignored unless IDLE
abort  in  1  terminate the current frame and force the clear sequence
pixelIn  in  1  binary pixel
pixelValid  in  1  pixelIn is valid
pixelReady  out  1  controller accepts the pixel this cycle
xAddress  out  ADDR_W  to histogram
yAddress  out  ADDR_W  to histogram
pixelData  out  1  to histogram
startHistogram / stopHistogram / readHistogram / clearHistogram  out  1 each  histogram controls
xHistogramOut / yHistogramOut  in  BIN_W each  histogram read data
xValid / yValid  in  1 each  one cycle per bin, ascending bin order from 0
histogramClear  in  1  histogram reports clear complete
xPeakIdx / yPeakIdx  out  ADDR_W each  bin index with the maximum count
xPeakCnt / yPeakCnt  out  BIN_W each  maximum count
resultValid  out  1  one-cycle pulse when peaks are updated
busy  out  1  high in every state except IDLE
timeoutErr  out  1  sticky; cleared by reset or the next accepted frameStart

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE -> START -> SCAN -> STOP -> READ -> COLLECT -> CLEAR -> WAIT_CLR -> IDLE. All transitions are registered.
- IDLE -> START: on frameStart. START drives startHistogram for 1 cycle with addresses (0,0).
- SCAN:
  - pixelReady = 1.
  - On pixelValid & pixelReady: pixelData = pixelIn registered with the current (x,y). y increments; at y = Y_HEIGHT-1, y wraps to 0 and x increments.
  - The transfer of (X_WIDTH-1, Y_HEIGHT-1) moves to STOP. pixelReady is 0 in that next cycle.
  - Stall cycles (pixelValid = 0): pixelData = 0 with addresses held, so no bin is counted.
- STOP: stopHistogram high for exactly STOP_CYCLES cycles; pixelData = 0.
- READ: readHistogram high for 1 cycle.
- COLLECT:
  - Separate x and y bin counters advance on xValid and yValid respectively.
  - Each axis keeps the running max using strict greater-than, so on ties the lowest index wins. An all-zero axis yields idx 0, cnt 0.
  - Exits once X_WIDTH x-beats and Y_HEIGHT y-beats have arrived. The peak outputs then update and resultValid pulses for 1 cycle.
  - Valid beats beyond the expected count are ignored.
- CLEAR: clearHistogram high for 1 cycle.
- WAIT_CLR: waits for histogramClear = 1, then goes to IDLE.
- Timeout: a COLLECT or WAIT_CLR dwell of TIMEOUT cycles sets timeoutErr. COLLECT then goes to CLEAR without resultValid; WAIT_CLR goes to IDLE.
- abort in START, SCAN, STOP, READ or COLLECT: go to CLEAR next cycle. No resultValid is produced and no stop pulse is issued if the abort occurs before STOP. abort in CLEAR, WAIT_CLR or IDLE has no effect.
- Simultaneous events: abort takes priority over the last-pixel transfer and over collect completion. frameStart while busy is dropped.
- Peak outputs hold their last value until the next resultValid.
- A mid-frame reset discards all progress; the histogram is not cleared by this block in that case.
- Latency: the first pixel is accepted in the cycle after START. There is no back-pressure on xValid/yValid; every beat is consumed.

Decomposition:
- Package hist_ctrl_pkg holds:
  - the state enumeration (3-bit encoding)
  - default frame dimensions
  - widths ADDR_W and BIN_W
- Sub-module hist_peak_tracker (running max and index over a valid stream, with clear input) is instantiated once per axis.

Test Plan:
- Frame of all zeros with pixelValid held high: exactly 43200 accepted pixels, one start pulse, 2-cycle stop pulse, then resultValid with xPeakIdx=0, xPeakCnt=0, yPeakIdx=0, yPeakCnt=0.
- Column 17 all ones, other pixels 0: x bin 17=180 -> xPeakIdx=17, xPeakCnt=180. y bins all 1 -> yPeakIdx=0, yPeakCnt=1.
- Random pixelValid gaps (50%): every stall cycle shows pixelData=0 with addresses held; address sequence and final peaks match the gap-free run.
- Ties: x bins 5 and 9 both 100 (others lower) -> xPeakIdx=5.
- abort at pixel 1000 -> next cycle CLEAR, clearHistogram pulse, no resultValid; histogramClear returns state to IDLE; a new frameStart is accepted.
- histogramClear never asserted -> after TIMEOUT cycles timeoutErr=1 and busy=0. A frameStart during the wait is ignored; the first frameStart after return to IDLE clears timeoutErr.
